// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: zeroes X1..X31 after reset/clear, then
// shares the single write port round-robin among NREQ writeback requesters.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [XLEN*NREQ-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [4:0]           writeR,
    output logic [XLEN-1:0]      write_data,
    output logic                 write,
    output logic                 init_done
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [4:0]      wr_d;
    logic [XLEN-1:0] data_d;
    logic            write_d, done_d;

    wb_req_t [NREQ-1:0] req;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign req[k].rd   = req_rd[5*k +: 5];
        assign req[k].data = req_data[XLEN*k +: XLEN];
    end

    // Rotating priority search starting at ptr; first valid requester wins.
    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;

    always_comb begin
        logic [PW:0] idx;
        idx     = '0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ))
                idx = idx - (PW+1)'(NREQ);
            if (!gnt_any && req_valid[idx[PW-1:0]]) begin
                gnt_any              = 1'b1;
                gnt_idx              = idx[PW-1:0];
                gnt[idx[PW-1:0]]     = 1'b1;
            end
        end
    end

    // clear overrides arbitration in the same cycle, so no transfer can slip in.
    logic arb_en, xfer;
    assign arb_en    = (state_q == RUN) && !clear;
    assign req_ready = arb_en ? gnt : '0;
    assign xfer      = arb_en && gnt_any;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        wr_d    = writeR;
        data_d  = write_data;
        write_d = 1'b0;
        done_d  = init_done;
        if (clear) begin
            state_d = INIT;
            cnt_d   = 5'd1;
            ptr_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    write_d = 1'b1;
                    wr_d    = cnt_q;
                    data_d  = '0;
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        wr_d    = req[gnt_idx].rd;
                        data_d  = req[gnt_idx].data;
                        // X0 is hardwired zero: consume the request but drop the write.
                        write_d = (req[gnt_idx].rd != 5'd0);
                        ptr_d   = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            cnt_q      <= 5'd1;
            ptr_q      <= '0;
            writeR     <= '0;
            write_data <= '0;
            write      <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            writeR     <= wr_d;
            write_data <= data_d;
            write      <= write_d;
            init_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed plan steps plus a randomized phase,
// checked against a queue-based model of the sweep and a round-robin search.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int XLEN = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_rd;
    logic [XLEN*NREQ-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic [4:0]           writeR;
    logic [XLEN-1:0]      write_data;
    logic                 write;
    logic                 init_done;

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready), .writeR(writeR), .write_data(write_data),
        .write(write), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: pending sweep writes as a queue; init_done means the queue is drained.
    int          sweep_q[$];
    int          last_k;
    int          last_g;
    logic        exp_write;
    logic [4:0]  exp_wr;
    logic [63:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_restart();
        sweep_q.delete();
        for (int r = 1; r <= 31; r++) sweep_q.push_back(r);
        last_k = NREQ - 1;
    endtask

    function automatic int pick();
        int k;
        if (sweep_q.size() != 0 || clear) return -1;
        for (int i = 1; i <= NREQ; i++) begin
            k = (last_k + i) % NREQ;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic v, input logic [4:0] rd, input logic [63:0] d);
        req_valid[k]          = v;
        req_rd[5*k +: 5]      = rd;
        req_data[XLEN*k +: XLEN] = d;
    endtask

    task automatic cycle();
        int g;
        logic [NREQ-1:0] eg;
        #1;
        g  = pick();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(eg));
        @(posedge clk);
        if (clear) begin
            model_restart();
            exp_write = 1'b0;
        end else if (sweep_q.size() != 0) begin
            exp_write = 1'b1;
            exp_wr    = 5'(sweep_q.pop_front());
            exp_data  = '0;
        end else if (g >= 0) begin
            exp_wr    = req_rd[5*g +: 5];
            exp_data  = req_data[XLEN*g +: XLEN];
            exp_write = (exp_wr != 5'd0);
            last_k    = g;
        end else begin
            exp_write = 1'b0;
        end
        last_g = g;
        #1;
        chk("write", 64'(write), 64'(exp_write));
        chk("writeR", 64'(writeR), 64'(exp_wr));
        chk("write_data", write_data, exp_data);
        chk("init_done", 64'(init_done), 64'(sweep_q.size() == 0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_restart();
        exp_write = 1'b0;
        exp_wr    = '0;
        exp_data  = '0;
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_writeR", 64'(writeR), 64'd0);
        chk("rst_write_data", write_data, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        clear     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        last_g    = -1;

        // Reset release and full sweep with no requests
        do_reset();
        for (int i = 0; i < 31; i++) begin
            cycle();
            chk("sweep_writeR", 64'(writeR), 64'(i + 1));
            chk("sweep_write", 64'(write), 64'd1);
            chk("sweep_done", 64'(init_done), 64'(i == 30));
        end
        cycle();
        chk("post_sweep_write", 64'(write), 64'd0);

        // All three requesters continuously valid
        set_req(0, 1'b1, 5'd1, 64'h1111);
        set_req(1, 1'b1, 5'd2, 64'h2222);
        set_req(2, 1'b1, 5'd3, 64'h3333);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_grant", 64'(last_g), 64'(i % 3));
            chk("rr_writeR", 64'(writeR), 64'(i % 3 + 1));
            chk("rr_write", 64'(write), 64'd1);
        end

        // Requester 0 targeting X0: consumed, no write
        set_req(1, 1'b0, 5'd0, 64'd0);
        set_req(2, 1'b0, 5'd0, 64'd0);
        set_req(0, 1'b1, 5'd0, 64'hFFFF);
        #1;
        chk("x0_ready", 64'(req_ready), 64'b001);
        cycle();
        chk("x0_write", 64'(write), 64'd0);
        set_req(0, 1'b1, 5'd7, 64'h7);
        set_req(1, 1'b1, 5'd8, 64'h8);
        set_req(2, 1'b1, 5'd9, 64'h9);
        cycle();
        chk("ptr_after_x0", 64'(last_g), 64'd1);

        // Single requester 1
        set_req(0, 1'b0, 5'd0, 64'd0);
        set_req(2, 1'b0, 5'd0, 64'd0);
        set_req(1, 1'b1, 5'd5, 64'hDEAD_BEEF);
        #1;
        chk("single_ready", 64'(req_ready), 64'b010);
        cycle();
        chk("single_write", 64'(write), 64'd1);
        chk("single_writeR", 64'(writeR), 64'd5);
        chk("single_data", write_data, 64'hDEAD_BEEF);
        set_req(1, 1'b0, 5'd0, 64'd0);
        cycle();
        chk("single_idle", 64'(write), 64'd0);

        // clear in RUN while requester 2 waits
        set_req(2, 1'b1, 5'd12, 64'hC0FFEE);
        clear = 1'b1;
        #1;
        chk("clear_ready", 64'(req_ready), 64'd0);
        cycle();
        chk("clear_done", 64'(init_done), 64'd0);
        chk("clear_write", 64'(write), 64'd0);
        clear = 1'b0;
        for (int i = 0; i < 31; i++) begin
            cycle();
            chk("resweep_nogrant", 64'(last_g), 64'hFFFF_FFFF_FFFF_FFFF);
            chk("resweep_writeR", 64'(writeR), 64'(i + 1));
        end
        cycle();
        chk("clear_late_grant", 64'(last_g), 64'd2);
        chk("clear_late_writeR", 64'(writeR), 64'd12);
        set_req(2, 1'b0, 5'd0, 64'd0);

        // Async reset in the middle of the sweep
        do_reset();
        for (int i = 0; i < 10; i++) cycle();
        chk("mid_writeR", 64'(writeR), 64'd10);
        #2;
        do_reset();
        cycle();
        chk("restart_writeR", 64'(writeR), 64'd1);
        chk("restart_write", 64'(write), 64'd1);

        // Randomized traffic with occasional clear
        for (int n = 0; n < 600; n++) begin
            clear = ($urandom_range(0, 49) == 0);
            if (last_g >= 0) req_valid[last_g] = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] && $urandom_range(0, 1) == 1)
                    set_req(k, 1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32 x 64-bit integer register file. After reset it sequences a hardware sweep that zeroes X1..X31 through the register file's single write port. It then shares that port round-robin among NREQ writeback requesters (ALU, load unit, CSR unit) using a valid/ready handshake. Its registered outputs drive the register file's `writeR`, `write_data` and `write` inputs directly.

## Interface
- NREQ, 3: number of writeback requesters; index 0 is the highest priority after reset.
- XLEN, 64: data width.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = in reset).
- clear  input  1  synchronous re-initialise request; restarts the zeroing sweep.
- req_valid  input  NREQ  requester k has a pending write.
- req_rd  input  5*NREQ  destination register of requester k, in bits [5k+4:5k].
- req_data  input  XLEN*NREQ  write data of requester k, in bits [XLEN*k+XLEN-1:XLEN*k].
- req_ready  output  NREQ  one-hot grant; combinational; transfer occurs when req_valid[k] & req_ready[k].
- writeR  output  5  register-file write index (registered).
- write_data  output  XLEN  register-file write data (registered).
- write  output  1  register-file write enable (registered).
- init_done  output  1  high once the zeroing sweep has completed (registered).

## Operation
- States: INIT and RUN. Internal state: 5-bit sweep counter `cnt` and round-robin pointer `ptr` (0..NREQ-1).
- Reset (rst=0), asynchronous:
  - Outputs: write=0, writeR=0, write_data=0, init_done=0.
  - Internal: state=INIT, cnt=1, ptr=0.
  - req_ready is 0 whenever state is INIT.
- INIT, on each clock edge:
  - Load write=1, writeR=cnt, write_data=0, then increment cnt.
  - When cnt==31, go to RUN and set init_done=1 on the same edge.
  - Requests are never granted in INIT.
  - X0 is never written by the sweep.
- RUN arbitration:
  - Search order is ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready is asserted only for the first k in that order with req_valid[k]=1.
  - All req_ready bits are 0 if no requester is valid or clear=1.
- RUN transfer on requester k:
  - Next edge loads writeR=req_rd[k] and write_data=req_data[k].
  - write=1, unless req_rd[k]==0, in which case write=0. The request is still consumed and acknowledged.
  - ptr updates to (k+1) mod NREQ.
- RUN with no transfer: write=0 on the next edge. writeR and write_data hold their previous values.
- Requester rules:
  - Once req_valid[k] is asserted, req_valid[k], req_rd[k] and req_data[k] stay stable until the transfer.
  - The arbiter does not queue requests. A requester that is not granted simply waits.
- clear=1 (sampled in either state):
  - Next edge: state=INIT, cnt=1, ptr=0, init_done=0, write=0.
  - The full 31-cycle sweep then reruns.
  - clear during INIT restarts the sweep from X1.
- Because writeR is always 1..31 while write=1 in INIT, and rd==0 suppresses write in RUN, X0 never receives a write from this block.

## Timing
- Sweep:
  - The first edge after rst rises drives writeR=1.
  - writeR=31 is presented on the 31st edge. init_done rises on that same edge.
  - The earliest possible req_ready is in the cycle after the 31st edge.
- Grant-to-write latency is 1 cycle: a transfer at edge N presents write=1 from edge N until edge N+1.
- Throughput is 1 transfer per cycle.
- Fairness: under continuous requests from all NREQ requesters, each is granted exactly once per NREQ cycles.
- Simultaneous clear and valid requests: clear wins, and no transfer occurs.
- rst asserted mid-sweep or mid-transfer clears all outputs immediately. The in-flight register write is lost.

## Test plan
- Reset release, no requests:
  - Required: writeR steps 1..31 on edges 1..31, each with write=1 and write_data=0.
  - Required: init_done=1 from edge 31; write=0 from edge 32 onward.
- Single requester after init, req_valid=3'b010, rd=5, data=64'hDEAD_BEEF:
  - Required: req_ready=3'b010 in the same cycle.
  - Required: next cycle write=1, writeR=5, write_data=64'hDEAD_BEEF; then write=0.
- All three requesters valid continuously, with rd=1, 2, 3:
  - Required: grants in order 0, 1, 2, 0, 1, 2.
  - Required: writeR sequence 1, 2, 3, 1, 2, 3 with write=1 every cycle.
- Requester 0 with rd=0, data=64'hFFFF:
  - Required: req_ready[0]=1 and the request is consumed.
  - Required: next cycle write=0; ptr advances to 1.
- clear pulsed in RUN while requester 2 is valid:
  - Required: no grant that cycle; next cycle init_done=0 and write=0.
  - Required: the sweep then rewrites X1..X31, and requester 2 is granted only after init_done returns to 1.
- rst driven low at sweep step 10:
  - Required: write=0 and init_done=0 immediately.
  - Required: after release the sweep restarts at writeR=1.
